// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;
    logic             ovf_o;

    modport master (
        output valid_i, a_i, b_i, sub_i, ready_i,
        input  ready_o, valid_o, s_o, c_o, ovf_o
    );

    modport slave (
        input  valid_i, a_i, b_i, sub_i, ready_i,
        output ready_o, valid_o, s_o, c_o, ovf_o
    );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes on both sides.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    serial_add_sub_if.slave  bus_if
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT:0]     slice_c;
    logic               accept_c;
    logic               busy_c;
    logic               last_c;

    assign accept_c = (state_q == ST_IDLE) && bus_if.valid_i;
    assign busy_c   = (state_q == ST_BUSY);
    assign last_c   = busy_c && (cnt_q == CNT_W'(N - 1));

    // The only adder in the block: one digit plus the running carry.
    assign slice_c = (DIGIT+1)'(a_q[DIGIT-1:0]) + (DIGIT+1)'(b_q[DIGIT-1:0])
                   + (DIGIT+1)'(carry_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus_if.valid_i) state_d = ST_BUSY;
            ST_BUSY: if (last_c)         state_d = ST_DONE;
            ST_DONE: if (bus_if.ready_i) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_if.ready_o = (state_q == ST_IDLE);
        bus_if.valid_o = (state_q == ST_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        if (accept_c) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_d     = bus_if.a_i;
            b_d     = bus_if.b_i ^ {WIDTH{bus_if.sub_i}};
            carry_d = bus_if.sub_i;
            cnt_d   = '0;
        end else if (busy_c) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            s_d     = (s_q >> DIGIT) | (WIDTH'(slice_c[DIGIT-1:0]) << (WIDTH - DIGIT));
            carry_d = slice_c[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_c) c_d = slice_c[DIGIT];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_if.s_o = s_q;
    assign bus_if.c_o = c_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic cin_msb_c;
    logic ovf_q, ovf_d;

    // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
    assign cin_msb_c = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_c[DIGIT-1];

    always_comb begin
        ovf_d = ovf_q;
        if (last_c) ovf_d = cin_msb_c ^ slice_c[DIGIT];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus_if.ovf_o = ovf_q;
`else
    assign bus_if.ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed vectors, random ops against an
// arithmetic reference model, backpressure, mid-operation reset and an 8/8 instance.
module tb_serial_add_sub;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    serial_add_sub_if #(.WIDTH(16)) bus ();
    serial_add_sub_if #(.WIDTH(8))  bus8 ();

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus.slave)
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic ovf_exp(input logic ovf);
`ifdef SERIAL_ADD_SUB_OVF_EN
        return ovf;
`else
        return 1'b0 & ovf;
`endif
    endfunction

    // Reference: plain integer arithmetic, overflow = signed result out of range.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int unsigned ua, ub;
        int          sa, sb, r;
        logic [15:0] s;
        logic        c;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        if (!sub) begin
            s = 16'(ua + ub);
            c = (ua + ub) > 32'd65535;
            r = sa + sb;
        end else begin
            s = 16'(ua - ub);
            c = ua >= ub;
            r = sa - sb;
        end
        return {ovf_exp((r > 32767) || (r < -32768)), c, s};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [15:0] s, output logic c, output logic ovf, output int lat);
        @(negedge clk);
        bus.a_i = a; bus.b_i = b; bus.sub_i = sub; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.a_i = 16'($urandom); bus.b_i = 16'($urandom); bus.sub_i = 1'($urandom);
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = bus.s_o; c = bus.c_o; ovf = bus.ovf_o;
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        check("idle_after_handshake", {30'd0, bus.ready_o, bus.valid_o}, 32'b10);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] s;
        logic        c, ovf;
        logic [17:0] m;
        int          lat;
        logic        seen;

        n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.sub_i = 1'b0;
        bus8.valid_i = 1'b0; bus8.ready_i = 1'b0; bus8.a_i = '0; bus8.b_i = '0; bus8.sub_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hs", {30'd0, bus.ready_o, bus.valid_o}, 32'b10);
        check("reset_out", {14'd0, bus.s_o, bus.c_o, bus.ovf_o}, 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, s, c, ovf, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_s", i), {16'd0, s}, {16'd0, vecs[i].s});
            check($sformatf("vec%0d_c", i), {31'd0, c}, {31'd0, vecs[i].c});
            check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, ovf_exp(vecs[i].ovf)});
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            m = model(ra, rb, rs);
            run_op(ra, rb, rs, s, c, ovf, lat);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
            check($sformatf("rnd%0d_res a=%h b=%h sub=%b", i, ra, rb, rs),
                  {14'd0, ovf, c, s}, {14'd0, m});
        end

        // Backpressure: result held while ready_i=0, extra requests ignored.
        m = model(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        bus.a_i = 16'h1111; bus.b_i = 16'h2222; bus.sub_i = 1'b0; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.valid_i = 1'b1; bus.a_i = 16'($urandom); bus.b_i = 16'($urandom); bus.sub_i = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", i), {12'd0, bus.ready_o, bus.valid_o, bus.ovf_o, bus.c_o, bus.s_o},
                  {12'd0, 1'b0, 1'b1, m});
        end
        @(negedge clk);
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        check("bp_release", {30'd0, bus.ready_o, bus.valid_o}, 32'b10);
        @(posedge clk); #1;
        check("bp_no_queue", {30'd0, bus.ready_o, bus.valid_o}, 32'b10);
        run_op(16'h0F0F, 16'h00FF, 1'b1, s, c, ovf, lat);
        check("bp_next", {14'd0, ovf, c, s}, {14'd0, model(16'h0F0F, 16'h00FF, 1'b1)});

        // Reset during the second BUSY cycle aborts the operation.
        @(negedge clk);
        bus.a_i = 16'h4321; bus.b_i = 16'h1234; bus.sub_i = 1'b0; bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_hs", {30'd0, bus.ready_o, bus.valid_o}, 32'b10);
        check("rst_out", {14'd0, bus.s_o, bus.c_o, bus.ovf_o}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen |= bus.valid_o;
        end
        check("rst_no_result", {31'd0, seen}, 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, s, c, ovf, lat);
        check("rst_after", {14'd0, ovf, c, s}, {14'd0, 1'b0, 1'b0, 16'h0002});

        // WIDTH=8, DIGIT=8: single-cycle registered adder.
        @(negedge clk);
        bus8.a_i = 8'h80; bus8.b_i = 8'h01; bus8.sub_i = 1'b1; bus8.valid_i = 1'b1;
        @(posedge clk); #1;
        bus8.valid_i = 1'b0;
        lat = 0;
        while (!bus8.valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_lat", 32'(lat), 32'd1);
        check("w8_res", {22'd0, bus8.ovf_o, bus8.c_o, bus8.s_o}, {22'd0, ovf_exp(1'b1), 1'b1, 8'h7F});
        @(negedge clk);
        bus8.ready_i = 1'b1;
        @(posedge clk); #1;
        bus8.ready_i = 1'b0;
        check("w8_idle", {30'd0, bus8.ready_o, bus8.valid_o}, 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
